// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: MEM_DEPTH x 32-bit storage, WAIT_STATES programmable
// wait cycles per data phase, byte/halfword/word writes, pipelined transfers.
// Optional macro AHB_SRAM_ERR_RESP_EN enables two-cycle ERROR responses for
// out-of-range, oversize or misaligned transfers; without it such addresses
// wrap, oversize is treated as word and misaligned addresses are aligned.
module ahb_sram_slave #(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    // Counter preload; WAIT is skipped entirely when WAIT_STATES is 0.
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]    state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [3:0]    be_q, be_d;
    logic          wr_q, wr_d;

    logic [31:0]   mem [MEM_DEPTH];

    logic          accept;
    logic          addr_err;
    logic [3:0]    be_new;

    // Bus sideband signals carry no meaning for plain SRAM.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR};

    // New address phases are taken whenever the slave is not stalling the bus.
    assign accept = HSEL && HREADY && HTRANS[1] &&
                    (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2);

`ifdef AHB_SRAM_ERR_RESP_EN
    assign addr_err = (|HADDR[31:AW+2]) || (HSIZE > 3'd2) ||
                      (HSIZE == 3'd1 && HADDR[0]) ||
                      (HSIZE == 3'd2 && (|HADDR[1:0]));
`else
    assign addr_err = 1'b0;
`endif

    // Little-endian lane enables; alignment is forced by ignoring low address bits.
    always_comb begin
        be_new = 4'b1111;
        if (HSIZE == 3'd0)
            be_new = 4'b0001 << HADDR[1:0];
        else if (HSIZE == 3'd1)
            be_new = HADDR[1] ? 4'b1100 : 4'b0011;
    end

    // Transfer FSM: wait countdown, error sequence and pipelined acceptance.
    always_comb begin
        state_d = S_IDLE;
        wcnt_d  = wcnt_q;
        widx_d  = widx_q;
        be_d    = be_q;
        wr_d    = wr_q;
        case (state_q)
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_WAIT;
                    wcnt_d  = wcnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            widx_d = HADDR[AW+1:2];
            be_d   = be_new;
            wr_d   = HWRITE;
            if (addr_err) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                wcnt_d  = WS_LOAD;
            end else begin
                state_d = S_DATA;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            widx_q  <= '0;
            be_q    <= 4'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            widx_q  <= widx_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
        end
    end

    // Write commit at the edge closing DATA; storage is never cleared by reset.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state_q == S_DATA && wr_q) begin
            for (int i = 0; i < 4; i++)
                if (be_q[i])
                    mem[widx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
    end

    // Asynchronous array read makes a just-committed write visible next cycle.
    assign HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
    assign HRDATA    = (state_q == S_DATA && !wr_q) ? mem[widx_q] : 32'h0;
`ifdef AHB_SRAM_ERR_RESP_EN
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
    assign HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench: two SRAM slaves (0 and 2 wait states) on one shared AHB bus,
// directed cases plus random pipelined traffic against a word-array model.
module tb_ahb_sram_slave;

    localparam int NT = 64;
`ifdef AHB_SRAM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        hsel, hwrite, sel;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        ro0, ro2, rs0, rs2;
    logic [31:0] rd0, rd2;
    logic        hready, hresp;
    logic [31:0] hrdata;

    always #5 HCLK = ~HCLK;

    assign hready = sel ? ro2 : ro0;
    assign hresp  = sel ? rs2 : rs0;
    assign hrdata = sel ? rd2 : rd0;

    ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && !sel), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0),
        .HPROT(4'd3), .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));

    ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && sel), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0),
        .HPROT(4'd3), .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2));

    int errors = 0;
    int checks = 0;

    // Transfer list and recorded results
    logic        t_wr [NT];
    logic [31:0] t_ad [NT];
    logic [2:0]  t_sz [NT];
    logic [31:0] t_wd [NT];
    logic [31:0] g_rd [NT];
    logic        g_rs [NT];
    int          g_wt [NT];

    // Reference storage per slave, one 32-bit word per entry
    logic [31:0] mm [2][1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic [31:0] a, input logic [2:0] sz);
        logic bad;
        bad = (a >= 32'h1000) || (sz > 3'd2) || ((sz <= 3'd2) && ((a % (32'd1 << sz)) != 0));
        return ERR_EN && bad;
    endfunction

    function automatic void mwrite(input int k, input logic [31:0] a, input logic [2:0] sz,
                                   input logic [31:0] d);
        int nb = (sz >= 3'd2) ? 4 : (1 << sz);
        int lo = (int'(a[1:0]) / nb) * nb;
        int w  = int'((a >> 2) & 32'h3FF);
        for (int b = lo; b < lo + nb; b++)
            mm[k][w][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic setx(input int i, input logic wr, input logic [31:0] ad,
                        input logic [2:0] sz, input logic [31:0] wd);
        t_wr[i] = wr; t_ad[i] = ad; t_sz[i] = sz; t_wd[i] = wd;
    endtask

    // Called at the negedge where transfer i's data phase ends with HREADY high
    task automatic complete(input int k, input int i);
        logic        err;
        logic [31:0] exp_rd;
        int          w;
        err = is_err(t_ad[i], t_sz[i]);
        w   = int'((t_ad[i] >> 2) & 32'h3FF);
        g_rd[i] = hrdata;
        g_rs[i] = hresp;
        chk($sformatf("waits[%0d]@%h", i, t_ad[i]), 32'(g_wt[i]), err ? 32'd1 : (k == 1 ? 32'd2 : 32'd0));
        chk($sformatf("resp[%0d]@%h", i, t_ad[i]), 32'(hresp), 32'(err));
        exp_rd = (!err && !t_wr[i]) ? mm[k][w] : 32'h0;
        chk($sformatf("rdata[%0d]@%h", i, t_ad[i]), hrdata, exp_rd);
        if (!err && t_wr[i])
            mwrite(k, t_ad[i], t_sz[i], t_wd[i]);
    endtask

    // Issue transfers 0..n-1 fully pipelined; must be entered at a negedge
    task automatic run(input int n);
        int dp  = -1;
        int nx  = 0;
        int cyc = 0;
        int k   = sel ? 1 : 0;
        for (int i = 0; i < n; i++) g_wt[i] = 0;
        while (cyc < 10 * n + 20) begin
            if (nx < n) begin
                hsel = 1'b1; htrans = 2'b10; hwrite = t_wr[nx];
                haddr = t_ad[nx]; hsize = t_sz[nx];
            end else begin
                hsel = 1'b0; htrans = 2'b00;
            end
            if (dp >= 0) hwdata = t_wd[dp];
            if (dp >= 0 && !hready) g_wt[dp]++;
            if (hready) begin
                if (dp >= 0) complete(k, dp);
                if (nx < n) begin dp = nx; nx++; end
                else dp = -1;
            end
            @(negedge HCLK);
            cyc++;
            if (dp < 0 && nx >= n) break;
        end
        chk("run_done", 32'(dp < 0 && nx >= n), 32'd1);
    endtask

    // BUSY with HSEL high must give a zero-wait OKAY and touch nothing
    task automatic idle_chk();
        hsel = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd2;
        hwdata = 32'hFFFF_FFFF;
        @(negedge HCLK);
        chk("busy_ready", 32'(hready), 32'd1);
        chk("busy_resp",  32'(hresp),  32'd0);
        chk("busy_rdata", hrdata, 32'h0);
        hsel = 1'b0; htrans = 2'b00;
        @(negedge HCLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        haddr = 32'h0; hsize = 3'd2; hwdata = 32'h0; HRESET = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("rst_ready0", 32'(ro0), 32'd1);
        chk("rst_resp0",  32'(rs0), 32'd0);
        chk("rst_rdata0", rd0, 32'h0);
        chk("rst_ready2", 32'(ro2), 32'd1);
        chk("rst_resp2",  32'(rs2), 32'd0);
        chk("rst_rdata2", rd2, 32'h0);

        // Release reset and present the first transfer in the same cycle
        HRESET = 1'b0;
        for (int i = 0; i < 32; i++) setx(i, 1'b1, 32'(4 * i), 3'd2, $urandom);
        run(32);
        sel = 1'b1;
        for (int i = 0; i < 32; i++) setx(i, 1'b1, 32'(4 * i), 3'd2, $urandom);
        run(32);

        // Word write then read back, zero waits
        sel = 1'b0;
        setx(0, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
        setx(1, 1'b0, 32'h10, 3'd2, 32'h0);
        run(2);
        chk("wr_rd_word", g_rd[1], 32'hDEAD_BEEF);

        // Byte lane merge
        setx(0, 1'b1, 32'h30, 3'd2, 32'h1122_3344);
        setx(1, 1'b1, 32'h31, 3'd0, 32'h0000_AA00);
        setx(2, 1'b0, 32'h30, 3'd2, 32'h0);
        run(3);
        chk("byte_merge", g_rd[2], 32'h1122_AA44);

        // Read directly after write to the same word
        setx(0, 1'b1, 32'h40, 3'd2, 32'h0000_0005);
        setx(1, 1'b0, 32'h40, 3'd2, 32'h0);
        run(2);
        chk("fwd_data", g_rd[1], 32'h0000_0005);
        chk("fwd_waits", 32'(g_wt[1]), 32'd0);

        // Out-of-range read
        setx(0, 1'b1, 32'h0, 3'd2, 32'hCAFE_F00D);
        setx(1, 1'b0, 32'h1000, 3'd2, 32'h0);
        run(2);
        chk("oor_resp",  32'(g_rs[1]), 32'(ERR_EN));
        chk("oor_waits", 32'(g_wt[1]), ERR_EN ? 32'd1 : 32'd0);
        chk("oor_rdata", g_rd[1], ERR_EN ? 32'h0 : 32'hCAFE_F00D);
        idle_chk();

        // Two wait states on a read
        sel = 1'b1;
        setx(0, 1'b0, 32'h20, 3'd2, 32'h0);
        run(1);
        chk("ws2_waits", 32'(g_wt[0]), 32'd2);
        chk("ws2_rdata", g_rd[0], mm[1][8]);

        // Reset in the middle of a write's wait states
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h50; hsize = 3'd2;
        @(posedge HCLK);
        #2;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_0077;
        @(negedge HCLK);
        chk("mid_wait_ready", 32'(ro2), 32'd0);
        #1 HRESET = 1'b1;
        #1;
        chk("arst_ready", 32'(ro2), 32'd1);
        chk("arst_resp",  32'(rs2), 32'd0);
        chk("arst_rdata", rd2, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        setx(0, 1'b0, 32'h50, 3'd2, 32'h0);
        run(1);
        chk("abandon_wr", g_rd[0], mm[1][20]);

        // Random pipelined traffic on both slaves
        for (int r = 0; r < 6; r++) begin
            sel = r[0];
            for (int i = 0; i < 40; i++) begin
                int s;
                int off;
                logic [31:0] ad;
                s   = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
                off = int'($urandom_range(0, 127));
                if ($urandom_range(0, 7) != 0)
                    off = off & ~((1 << ((s > 2) ? 2 : s)) - 1);
                ad = ($urandom_range(0, 5) == 0) ? ((32'($urandom_range(1, 3)) << 12) | 32'(off))
                                                 : 32'(off);
                setx(i, 1'($urandom_range(0, 1)), ad, 3'(s), $urandom);
            end
            run(40);
            idle_chk();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter MEM_DEPTH, default 1024: number of 32-bit words of storage; power of two.
REQ-002 Parameter WAIT_STATES, default 0, range 0-15: HREADYOUT-low cycles inserted in every non-error data phase.
REQ-003 HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 HRESET  input  1  asynchronous, active-high reset.
REQ-005 HSEL  input  1  slave select from decoder.
REQ-006 HADDR  input  32  byte address; word index = HADDR[log2(MEM_DEPTH)+1:2].
REQ-007 HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 HWRITE  input  1  1=write, 0=read.
REQ-009 HSIZE  input  3  0=byte, 1=halfword, 2=word.
REQ-010 HBURST, HPROT, HMASTLOCK  input  3/4/1  accepted, no effect on behaviour.
REQ-011 HWDATA  input  32  write data, valid in the write data phase.
REQ-012 HREADY  input  1  bus-level ready; qualifies address-phase sampling.
REQ-013 HREADYOUT  output  1  0 = extend current data phase.
REQ-014 HRESP  output  1  0=OKAY, 1=ERROR.
REQ-015 HRDATA  output  32  read data, valid when HREADYOUT=1 in a read data phase.

Function
REQ-016 A transfer SHALL be accepted on a rising HCLK edge where HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR, HWRITE and HSIZE are registered at that edge.
REQ-017 IDLE/BUSY, or HSEL=0, SHALL produce a zero-wait OKAY response with no storage access.
REQ-018 States SHALL be IDLE, WAIT, DATA, ERR1, ERR2; IDLE->WAIT on acceptance if WAIT_STATES>0, else IDLE->DATA; WAIT->DATA when wait counter reaches 0.
REQ-019 The wait counter SHALL load WAIT_STATES-1 on acceptance and decrement each cycle in WAIT; HREADYOUT=0 throughout WAIT.
REQ-020 In DATA, HREADYOUT=1 and HRESP=0; next state is WAIT/DATA if a new transfer is accepted in that cycle (pipelined), else IDLE.
REQ-021 Writes SHALL update only byte lanes selected by HSIZE and HADDR[1:0] (little-endian), committing at the edge ending DATA.
REQ-022 Reads SHALL drive the addressed full word on HRDATA in DATA; HRDATA SHALL be 0 at all other times.
REQ-023 A read immediately following a write to the same word SHALL return the newly written bytes (forwarding, no extra wait).
REQ-024 Back-to-back accepted transfers with WAIT_STATES=0 SHALL sustain one transfer per cycle.
REQ-025 Addresses beyond MEM_DEPTH words SHALL wrap modulo MEM_DEPTH unless REQ-031 applies.

Reset
REQ-026 HRESET high SHALL force, asynchronously, state IDLE, wait counter 0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-027 Reset asserted mid-WAIT or mid-DATA SHALL abandon the transfer; a pending write SHALL not commit.
REQ-028 Storage contents SHALL NOT be cleared by reset.
REQ-029 First transfer SHALL be accepted on the first rising edge after HRESET deasserts.

Configuration
REQ-030 Macro AHB_SRAM_ERR_RESP_EN SHALL select error checking.
REQ-031 Defined: out-of-range address, HSIZE>2, or HADDR misaligned to HSIZE SHALL give two-cycle ERROR: ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), no storage access, WAIT_STATES not applied; a transfer presented during ERR1 SHALL not be accepted.
REQ-032 Undefined: ERR1/ERR2 unreachable, HRESP tied 0, out-of-range wraps, HSIZE>2 treated as word, misaligned addresses forced to HSIZE alignment.

Verification
REQ-033 WAIT_STATES=0: write NONSEQ 0x10 word 0xDEADBEEF, then read 0x10 -> HRDATA=0xDEADBEEF in cycle after read address phase, HREADYOUT never low.
REQ-034 WAIT_STATES=2: read 0x20 -> HREADYOUT low exactly 2 cycles then high with OKAY and data.
REQ-035 Byte write 0xAA to 0x31 over word 0x11223344 at 0x30, read 0x30 -> 0x1122AA44.
REQ-036 Write 0x5 to 0x40 then immediate pipelined read of 0x40 -> 0x00000005 without added wait.
REQ-037 Macro defined, MEM_DEPTH=1024: read 0x1000 -> HREADYOUT 0/1 with HRESP 1/1; macro undefined -> OKAY, data of word 0.
REQ-038 Assert HRESET during WAIT of write 0x77 to 0x50 -> outputs reset immediately, later read 0x50 returns prior contents.
